// File: rtl/count_stop_gen_pkg.sv
// count_stop_gen_pkg: shared widths, saturation value and FSM state type
package count_stop_gen_pkg;
  localparam int CNT_W_D = 5;
  localparam int ERR_W_D = 8;
  localparam int ERR_MAX_D = 2 ** ERR_W_D - 1;
  typedef enum logic [1:0] {IDLE, START, RUN, CAPTURE} state_t;
endpackage

// File: rtl/count_stop_gen_if.sv
// count_stop_gen_if: control/counter-facing signals of the measurement initiator
interface count_stop_gen_if
  import count_stop_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_D,
  parameter int ERR_W = ERR_W_D
);
  logic             start_req;
  logic [CNT_W-1:0] win_len;
  logic [CNT_W-1:0] count_global;
  logic             srdyi_counter;
  logic             clk_stop;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count_capt;
  logic             match;
  logic             len_err;
  logic [ERR_W-1:0] mismatch_cnt;
  modport master (
    output start_req, win_len, count_global,
    input  srdyi_counter, clk_stop, busy, done, count_capt, match, len_err, mismatch_cnt
  );
  modport slave (
    input  start_req, win_len, count_global,
    output srdyi_counter, clk_stop, busy, done, count_capt, match, len_err, mismatch_cnt
  );
endinterface

// File: rtl/count_stop_gen_sat_counter.sv
// sat_counter: increment-by-one counter that sticks at its all-ones value
module sat_counter
  import count_stop_gen_pkg::*;
#(
  parameter int W = ERR_W_D
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  localparam logic [W-1:0] MAX = '1;
  // count up on inc, hold once saturated
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (inc && cnt != MAX) cnt <= cnt + W'(1);
endmodule

// File: rtl/count_stop_gen.sv
// count_stop_gen: issues start/stop strobes to the global counter and checks its result
module count_stop_gen
  import count_stop_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_D,
  parameter int ERR_W = ERR_W_D
) (
  input logic             clk,
  input logic             GlobalReset_n,
  count_stop_gen_if.slave bus
);
  state_t           state;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] cyc;
  logic             bad;
  assign bad = state == CAPTURE && bus.count_global != len;
  // window FSM: cyc holds the index of the current window cycle, all strobes registered
  always_ff @(posedge clk or negedge GlobalReset_n)
    if (!GlobalReset_n) begin
      state             <= IDLE;
      len               <= '0;
      cyc               <= '0;
      bus.srdyi_counter <= 1'b0;
      bus.clk_stop      <= 1'b0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.len_err       <= 1'b0;
      bus.count_capt    <= '0;
      bus.match         <= 1'b0;
    end else begin
      bus.srdyi_counter <= 1'b0;
      bus.clk_stop      <= 1'b0;
      bus.done          <= 1'b0;
      bus.len_err       <= 1'b0;
      case (state)
        IDLE:
          if (bus.start_req) begin
            if (bus.win_len == '0) bus.len_err <= 1'b1;
            else begin
              len               <= bus.win_len;
              cyc               <= '0;
              state             <= START;
              bus.srdyi_counter <= 1'b1;
              bus.clk_stop      <= bus.win_len == CNT_W'(1);
              bus.busy          <= 1'b1;
            end
          end
        START, RUN: begin
          cyc          <= cyc + CNT_W'(1);
          bus.clk_stop <= cyc + CNT_W'(1) == len - CNT_W'(1);
          state        <= cyc == len - CNT_W'(1) ? CAPTURE : RUN;
        end
        CAPTURE: begin
          bus.count_capt <= bus.count_global;
          bus.match      <= bus.count_global == len;
          bus.done       <= 1'b1;
          bus.busy       <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  sat_counter #(.W(ERR_W)) u_mis (
    .clk  (clk),
    .rst_n(GlobalReset_n),
    .inc  (bad),
    .cnt  (bus.mismatch_cnt)
  );
endmodule

// File: tb/tb_count_stop_gen.sv
// tb_count_stop_gen: directed vector bench with a simple global counter model
module tb_count_stop_gen;
  import count_stop_gen_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  count_stop_gen_if #(.CNT_W(5), .ERR_W(8)) bus ();
  count_stop_gen #(.CNT_W(5), .ERR_W(8)) dut (
    .clk          (clk),
    .GlobalReset_n(rst_n),
    .bus          (bus)
  );
  logic [4:0] mc;
  logic       mrun;
  logic       force_en;
  logic [4:0] force_v;
  // conforming counter: starts at 1 on the strobe edge, counts each cycle, freezes after clk_stop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mc   <= '0;
      mrun <= 1'b0;
    end else if (bus.srdyi_counter) begin
      mc   <= 5'd1;
      mrun <= !bus.clk_stop;
    end else if (mrun) begin
      mc   <= mc + 5'd1;
      mrun <= !bus.clk_stop;
    end
  assign bus.count_global = force_en ? force_v : mc;
  int checks = 0;
  int errors = 0;
  int exp_mis = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " srdyi"}, 32'(bus.srdyi_counter), 0);
    chk({tag, " clk_stop"}, 32'(bus.clk_stop), 0);
    chk({tag, " busy"}, 32'(bus.busy), 0);
    chk({tag, " done"}, 32'(bus.done), 0);
    chk({tag, " capt"}, 32'(bus.count_capt), 0);
    chk({tag, " match"}, 32'(bus.match), 0);
    chk({tag, " len_err"}, 32'(bus.len_err), 0);
    chk({tag, " mis"}, 32'(bus.mismatch_cnt), 0);
  endtask
  // starts at a negedge with the DUT idle, ends at the negedge of the done cycle
  task automatic run(input int len, input bit full, input bit fe, input int fv, input bit poke);
    force_en = fe;
    force_v = fv[4:0];
    bus.start_req = 1'b1;
    bus.win_len = len[4:0];
    @(posedge clk);
    for (int c = 0; c <= len + 1; c++) begin
      @(negedge clk);
      bus.start_req = poke && c == 1;
      bus.win_len = (poke && c == 1) ? 5'd2 : 5'd9;
      if (full) begin
        chk("srdyi", 32'(bus.srdyi_counter), 32'(c == 0));
        chk("clk_stop", 32'(bus.clk_stop), 32'(c == len - 1));
        chk("busy", 32'(bus.busy), 32'(c <= len));
        chk("done", 32'(bus.done), 32'(c == len + 1));
      end
    end
    if (!full) chk("done pulse", 32'(bus.done), 1);
  endtask
  task automatic chk_result(input string tag, input int capt, input bit m);
    if (!m) exp_mis = exp_mis < 255 ? exp_mis + 1 : 255;
    chk({tag, " capt"}, 32'(bus.count_capt), capt);
    chk({tag, " match"}, 32'(bus.match), 32'(m));
    chk({tag, " mis"}, 32'(bus.mismatch_cnt), exp_mis);
  endtask
  typedef struct {
    int len;
    bit fe;
    int fv;
    int exp_capt;
    bit exp_match;
  } vec_t;
  vec_t tv[7];
  initial begin
    tv[0] = '{5, 1'b0, 0, 5, 1'b1};
    tv[1] = '{1, 1'b0, 0, 1, 1'b1};
    tv[2] = '{31, 1'b0, 0, 31, 1'b1};
    tv[3] = '{2, 1'b0, 0, 2, 1'b1};
    tv[4] = '{5, 1'b1, 3, 3, 1'b0};
    tv[5] = '{7, 1'b0, 0, 7, 1'b1};
    tv[6] = '{16, 1'b1, 0, 0, 1'b0};
    bus.start_req = 1'b0;
    bus.win_len = '0;
    force_en = 1'b0;
    force_v = '0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.start_req = 1'b1;
    bus.win_len = 5'd0;
    @(negedge clk);
    bus.start_req = 1'b0;
    chk("len_err pulse", 32'(bus.len_err), 1);
    chk("len_err srdyi", 32'(bus.srdyi_counter), 0);
    chk("len_err busy", 32'(bus.busy), 0);
    @(negedge clk);
    chk("len_err drop", 32'(bus.len_err), 0);
    chk("len_err idle", 32'(bus.busy), 0);
    run(3, 1'b1, 1'b0, 0, 1'b0);
    chk_result("after len_err", 3, 1'b1);
    for (int i = 0; i < 7; i++) begin
      run(tv[i].len, 1'b1, tv[i].fe, tv[i].fv, 1'b0);
      chk_result($sformatf("vec%0d", i), tv[i].exp_capt, tv[i].exp_match);
    end
    run(4, 1'b1, 1'b0, 0, 1'b1);
    chk_result("busy ignore", 4, 1'b1);
    for (int i = 0; i < 300; i++) run(5, 1'b0, 1'b1, 3, 1'b0);
    exp_mis = 255;
    chk("saturate mis", 32'(bus.mismatch_cnt), 255);
    chk("saturate capt", 32'(bus.count_capt), 3);
    force_en = 1'b0;
    bus.start_req = 1'b1;
    bus.win_len = 5'd8;
    @(posedge clk);
    @(negedge clk);
    bus.start_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid-run busy", 32'(bus.busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk_zero("async reset");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no done in reset", 32'(bus.done), 0);
    end
    rst_n = 1'b1;
    exp_mis = 0;
    @(negedge clk);
    chk("post reset idle", 32'(bus.busy), 0);
    run(3, 1'b1, 1'b0, 0, 1'b0);
    chk_result("post reset", 3, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/count_stop_gen.md
Name: count_stop_gen

Overview:
- Initiator side of the global cycle-count measurement interface.
- On request, issues the single-cycle start strobe (srdyi_counter) to the global counter and holds the run open for a programmed window.
- Asserts clk_stop on the last window cycle, then captures the counter's result and checks it against the programmed length.
- Sits between test/control logic and the global counter. Provides done/match status and a saturating mismatch tally.

Parameters:
CNT_W, 5, width of window length and of the counter value (must equal counter width)
ERR_W, 8, width of the saturating mismatch counter

Ports:
clk  input  1  system clock; all state updates on rising edge
GlobalReset_n  input  1  asynchronous, active-low reset
start_req  input  1  request a measurement; sampled only in IDLE
win_len  input  CNT_W  window length L in cycles, sampled with start_req; legal 1..2^CNT_W-1
count_global  input  CNT_W  result value from the global counter
srdyi_counter  output  1  start strobe to counter, registered, one cycle high
clk_stop  output  1  stop indication to counter, registered, one cycle high
busy  output  1  measurement in progress
done  output  1  one-cycle pulse: result captured
count_capt  output  CNT_W  captured count_global, held until next done
match  output  1  count_capt == latched L; valid with done, held until next done
len_err  output  1  one-cycle pulse: start_req with win_len==0 rejected
mismatch_cnt  output  ERR_W  saturating count of done pulses with match==0

Behaviour:
- Reset (GlobalReset_n low, asynchronous): state=IDLE. All outputs 0, latched L=0, cycle counter=0. Reset mid-run aborts at once, with no done or len_err pulse. srdyi_counter and clk_stop drop to 0 immediately.
- States: IDLE, START, RUN, CAPTURE.
- IDLE:
  - start_req=1, win_len!=0: latch L=win_len, go START.
  - start_req=1, win_len==0: len_err=1 for one cycle, stay IDLE, no strobe.
- Cycle numbering: cycle 0 is the START cycle, i.e. the interval following the edge that leaves IDLE.
- Output timing:
  - srdyi_counter=1 in cycle 0 only.
  - clk_stop=1 in cycle L-1 only. For L=1 this coincides with cycle 0, so both are high together.
  - busy=1 in cycles 0..L.
- START → RUN when L>1. START → CAPTURE when L==1.
- RUN: internal cycle counter (CNT_W bits) advances each cycle. Leave for CAPTURE at the end of cycle L-1.
- CAPTURE (cycle L): count_global has been stable since edge L. At the edge ending cycle L:
  - count_capt<=count_global;
  - match<=(count_global==L);
  - done<=1 for the following cycle;
  - if mismatch, mismatch_cnt increments, saturating at 2^ERR_W-1;
  - state goes IDLE.
- Expected result: with a conforming counter, count_capt==L. No wrap is possible since L<=2^CNT_W-1.
- start_req while busy is ignored; no queuing.
- start_req in the same cycle as done is accepted. The next srdyi_counter rises at least 2 cycles after the previous clk_stop, so the counter sees a clean rising edge.
- srdyi_counter is low for at least L+1 cycles between strobes.
- win_len changes after acceptance have no effect.
- count_capt, match and mismatch_cnt change only at a done edge or at reset.
- No combinational path from any input to any output.

Decomposition:
- Shared package:
  - state enum (IDLE/START/RUN/CAPTURE);
  - CNT_W default;
  - ERR_W default;
  - localparam for the saturation value.
- One natural sub-module: sat_counter (ERR_W-bit increment-with-saturation, async active-low clear), used for mismatch_cnt.
- FSM, window counter and capture registers stay in count_stop_gen.

Test Plan:
- L=5, bench counter model conforming → srdyi_counter high cycle 0, clk_stop high cycle 4, busy cycles 0..5, done cycle 6, count_capt=5, match=1, mismatch_cnt=0.
- L=1 → srdyi_counter and clk_stop both high in cycle 0, done cycle 2, count_capt=1, match=1.
- L=31 → clk_stop in cycle 30, count_capt=31, match=1.
- win_len=0 with start_req → len_err pulse, srdyi_counter stays 0, busy stays 0. Then start_req with win_len=3 → count_capt=3.
- Model forces count_global=3 for L=5 → match=0, mismatch_cnt=1. Repeat 300 runs → mismatch_cnt saturates at 255.
- GlobalReset_n low in cycle 2 of an L=8 run → all outputs 0 asynchronously, no done. start_req during busy is ignored, and back-to-back start on the done cycle is accepted.
